// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen bit-field library: the read and write side-effect
// selectors used as parameters by the field modules.
package rggen_rtl_pkg;

  // Side effect applied to the read-masked bits of a field on a read access.
  typedef enum logic [1:0] {
    RGGEN_READ_NONE  = 2'd0,
    RGGEN_READ_SET   = 2'd1,
    RGGEN_READ_CLEAR = 2'd2
  } rggen_read_action_e;

  // Side effect applied to the write-masked bits of a field on a write access.
  typedef enum logic [2:0] {
    RGGEN_WRITE_W0C = 3'd0,
    RGGEN_WRITE_W1C = 3'd1,
    RGGEN_WRITE_WC  = 3'd2,
    RGGEN_WRITE_W0S = 3'd3,
    RGGEN_WRITE_W1S = 3'd4,
    RGGEN_WRITE_WS  = 3'd5,
    RGGEN_WRITE_W   = 3'd6
  } rggen_write_action_e;

endpackage

// File: rtl/rggen_bit_field_if.sv
// Bus-side connection between a register block and one of its bit fields.
// The register block drives the access; the field returns its current value.
interface rggen_bit_field_if #(
  parameter int WIDTH = 1
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid, read_mask, write_mask, write_data,
    input  read_data, value
  );

  modport bit_field (
    input  valid, read_mask, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_sw_action.sv
// Software side of a bit field: turns the current value and one bus access
// into the value software wants (sw_next) and the bits it claims (sw_touch).
// A read with a non-zero mask takes precedence; a write applies only otherwise.
module rggen_bit_field_sw_action
  import rggen_rtl_pkg::*;
#(
  parameter int                  WIDTH        = 1,
  parameter rggen_read_action_e  READ_ACTION  = RGGEN_READ_NONE,
  parameter rggen_write_action_e WRITE_ACTION = RGGEN_WRITE_W1C
)(
  input  logic [WIDTH-1:0] value,
  input  logic             valid,
  input  logic [WIDTH-1:0] read_mask,
  input  logic [WIDTH-1:0] write_mask,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] sw_next,
  output logic [WIDTH-1:0] sw_touch
);

  // Apply the selected read or write side effect to the masked bits.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    sw_next  = value;
    sw_touch = '0;
    if (valid && (read_mask != '0)) begin
      case (READ_ACTION)
        RGGEN_READ_SET: begin
          sw_next  = value | read_mask;
          sw_touch = read_mask;
        end
        RGGEN_READ_CLEAR: begin
          sw_next  = value & ~read_mask;
          sw_touch = read_mask;
        end
        default: ;  // no read side effect: behaves as an idle cycle
      endcase
    end else if (valid && (write_mask != '0)) begin
      sw_touch = write_mask;
      case (WRITE_ACTION)
        RGGEN_WRITE_W0C: sw_next = value & ~(write_mask & ~write_data);
        RGGEN_WRITE_W1C: sw_next = value & ~(write_mask &  write_data);
        RGGEN_WRITE_WC:  sw_next = value & ~write_mask;
        RGGEN_WRITE_W0S: sw_next = value |  (write_mask & ~write_data);
        RGGEN_WRITE_W1S: sw_next = value |  (write_mask &  write_data);
        RGGEN_WRITE_WS:  sw_next = value |  write_mask;
        RGGEN_WRITE_W:   sw_next = (value & ~write_mask) | (write_data & write_mask);
        default:         sw_touch = '0;
      endcase
    end
  end

endmodule

// File: rtl/rggen_bit_field_rwcs_ext.sv
// Generalised read/write side-effect bit field with hardware set/clear events
// and 0->1 / 1->0 change pulses. Software and hardware updates are merged per
// bit; HW_PRIORITY selects which side wins on a bit both touch.
// Optional feature: define RGGEN_BIT_FIELD_HW_EDGE_DETECT_EN to make i_hw_set
// rising-edge sensitive instead of level sensitive.
module rggen_bit_field_rwcs_ext
  import rggen_rtl_pkg::*;
#(
  parameter int                  WIDTH         = 1,
  parameter logic [WIDTH-1:0]    INITIAL_VALUE = '0,
  parameter rggen_read_action_e  READ_ACTION   = RGGEN_READ_NONE,
  parameter rggen_write_action_e WRITE_ACTION  = RGGEN_WRITE_W1C,
  parameter bit                  HW_PRIORITY   = 1'b1
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  rggen_bit_field_if.bit_field bit_field_if,
  input  logic [WIDTH-1:0]     i_hw_set,
  input  logic [WIDTH-1:0]     i_hw_clear,
  output logic [WIDTH-1:0]     o_value,
  output logic                 o_any,
  output logic [WIDTH-1:0]     o_set_pulse,
  output logic [WIDTH-1:0]     o_clear_pulse
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] set_pulse_q;
  logic [WIDTH-1:0] clear_pulse_q;
  logic [WIDTH-1:0] sw_next;
  logic [WIDTH-1:0] sw_touch;
  logic [WIDTH-1:0] hw_set_eff;
  logic [WIDTH-1:0] hw_base;
  logic [WIDTH-1:0] hw_next;
  logic [WIDTH-1:0] hw_touch;
  logic [WIDTH-1:0] next_value;

  rggen_bit_field_sw_action #(
    .WIDTH        (WIDTH),
    .READ_ACTION  (READ_ACTION),
    .WRITE_ACTION (WRITE_ACTION)
  ) u_sw_action (
    .value      (value_q),
    .valid      (bit_field_if.valid),
    .read_mask  (bit_field_if.read_mask),
    .write_mask (bit_field_if.write_mask),
    .write_data (bit_field_if.write_data),
    .sw_next    (sw_next),
    .sw_touch   (sw_touch)
  );

`ifdef RGGEN_BIT_FIELD_HW_EDGE_DETECT_EN
  logic [WIDTH-1:0] hw_set_q;

  // Remember last cycle's set request so a held-high request acts only once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hw_set_q <= '0;
    end else begin
      hw_set_q <= i_hw_set;
    end
  end

  assign hw_set_eff = i_hw_set & ~hw_set_q;
`else
  assign hw_set_eff = i_hw_set;
`endif

  // Merge hardware and software updates per bit; set beats clear in hardware.
  always_comb begin
    hw_base    = HW_PRIORITY ? sw_next : value_q;
    hw_next    = (hw_base & ~i_hw_clear) | hw_set_eff;
    hw_touch   = i_hw_clear | hw_set_eff;
    next_value = value_q;
    if (HW_PRIORITY) begin
      next_value = (sw_next & ~hw_touch) | (hw_next & hw_touch);
    end else begin
      next_value = (sw_next & sw_touch)
                 | (hw_next & hw_touch & ~sw_touch)
                 | (value_q & ~(sw_touch | hw_touch));
    end
  end

  // Field register and its change pulses, updated on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      value_q       <= INITIAL_VALUE;
      set_pulse_q   <= '0;
      clear_pulse_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value_q, keeping the pulses consistent with it.
      value_q       <= next_value;
      set_pulse_q   <= next_value & ~value_q;
      clear_pulse_q <= ~next_value & value_q;
    end
  end

  assign bit_field_if.read_data = value_q;
  assign bit_field_if.value     = value_q;
  assign o_value                = value_q;
  assign o_any                  = |value_q;
  assign o_set_pulse            = set_pulse_q;
  assign o_clear_pulse          = clear_pulse_q;

endmodule

// File: tb/tb_rggen_bit_field_rwcs_ext.sv
// Bench for rggen_bit_field_rwcs_ext: fourteen 8-bit instances covering every
// write action, all read actions and both hardware priorities, driven by the
// same stimulus. Directed table, multi-cycle sequences, then random cycles
// against a per-bit reference model.
module tb_rggen_bit_field_rwcs_ext;
  import rggen_rtl_pkg::*;

  localparam int          NDUT = 14;
  localparam logic [7:0]  INIT = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] rm = '0, wm = '0, wd = '0, hs = '0, hc = '0;

  logic [7:0] obs_value [NDUT];
  logic [7:0] obs_sp    [NDUT];
  logic [7:0] obs_cp    [NDUT];
  logic       obs_any   [NDUT];
  logic [7:0] obs_rdata [NDUT];
  logic [7:0] obs_ifval [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance g: read action g%3, write action g%7, hardware priority for g<7.
  function automatic rggen_read_action_e ra_of(int g);
    case (g % 3)
      1:       return RGGEN_READ_SET;
      2:       return RGGEN_READ_CLEAR;
      default: return RGGEN_READ_NONE;
    endcase
  endfunction

  function automatic rggen_write_action_e wa_of(int g);
    case (g % 7)
      0:       return RGGEN_WRITE_W0C;
      1:       return RGGEN_WRITE_W1C;
      2:       return RGGEN_WRITE_WC;
      3:       return RGGEN_WRITE_W0S;
      4:       return RGGEN_WRITE_W1S;
      5:       return RGGEN_WRITE_WS;
      default: return RGGEN_WRITE_W;
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    rggen_bit_field_if #(.WIDTH(8)) bif ();
    assign bif.valid      = valid;
    assign bif.read_mask  = rm;
    assign bif.write_mask = wm;
    assign bif.write_data = wd;
    assign obs_rdata[g]   = bif.read_data;
    assign obs_ifval[g]   = bif.value;

    rggen_bit_field_rwcs_ext #(
      .WIDTH         (8),
      .INITIAL_VALUE (INIT),
      .READ_ACTION   (ra_of(g)),
      .WRITE_ACTION  (wa_of(g)),
      .HW_PRIORITY   (g < 7)
    ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .bit_field_if  (bif.bit_field),
      .i_hw_set      (hs),
      .i_hw_clear    (hc),
      .o_value       (obs_value[g]),
      .o_any         (obs_any[g]),
      .o_set_pulse   (obs_sp[g]),
      .o_clear_pulse (obs_cp[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] r, w, d, s, c);
    valid = v; rm = r; wm = w; wd = d; hs = s; hc = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference: decide each bit independently from the access rules.
  // ra: 0 none, 1 set, 2 clear. wa: 0 W0C .. 6 plain write. hse: effective set.
  function automatic logic [7:0] model_next(input logic [7:0] v, input int ra, input int wa,
                                            input bit prio, input logic vld,
                                            input logic [7:0] r, w, d, hse, c);
    logic [7:0] res;
    for (int i = 0; i < 8; i++) begin
      bit   touched = 0;
      logic sw_bit  = v[i];
      logic out_bit;
      if (vld && r != 0) begin
        if (ra != 0 && r[i]) begin
          touched = 1;
          sw_bit  = (ra == 1);
        end
      end else if (vld && w != 0 && w[i]) begin
        touched = 1;
        case (wa)
          0: sw_bit = d[i] ? v[i] : 1'b0;
          1: sw_bit = d[i] ? 1'b0 : v[i];
          2: sw_bit = 1'b0;
          3: sw_bit = d[i] ? v[i] : 1'b1;
          4: sw_bit = d[i] ? 1'b1 : v[i];
          5: sw_bit = 1'b1;
          default: sw_bit = d[i];
        endcase
      end
      if (prio) begin
        if (hse[i])      out_bit = 1'b1;
        else if (c[i])   out_bit = 1'b0;
        else             out_bit = sw_bit;
      end else begin
        if (touched)     out_bit = sw_bit;
        else if (hse[i]) out_bit = 1'b1;
        else if (c[i])   out_bit = 1'b0;
        else             out_bit = v[i];
      end
      res[i] = out_bit;
    end
    return res;
  endfunction

  typedef struct {
    logic       valid;
    logic [7:0] rm, wm, wd, hs, hc;
    logic [7:0] e1_v, e1_sp, e1_cp;  // instance 1: read SET, W1C, hw priority
    logic [7:0] e8_v;                // instance 8: read CLEAR, W1C, sw priority
  } vec_t;

  vec_t tbl [10];
  logic [7:0] exp_v [NDUT];
  logic [7:0] hs_prev;

  initial begin
    logic [7:0] prev1;
    logic [7:0] nxt [NDUT];
    logic [7:0] hse;

    tbl[0] = '{1'b1, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'hA0, 8'h00, 8'h05, 8'hA0};
    tbl[1] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA0, 8'h00, 8'h00, 8'hA0};
    tbl[2] = '{1'b1, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h50, 8'h00, 8'h00};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hF1, 8'h01, 8'h00, 8'h01};
    tbl[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF1, 8'h00, 8'h00, 8'h01};
    tbl[5] = '{1'b1, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h00, 8'hF1, 8'h00, 8'h00, 8'h00};
    tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'hF3, 8'h02, 8'h00, 8'h02};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h03, 8'h00, 8'hF0, 8'h02};
    tbl[8] = '{1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h02};
    tbl[9] = '{1'b1, 8'h0F, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'h0C, 8'h00, 8'h00};

    // Reset values.
    do_reset();
    check("reset value", obs_value[1], 8'hA5);
    check("reset set_pulse", obs_sp[1], 8'h00);
    check("reset clear_pulse", obs_cp[1], 8'h00);
    check("reset any", obs_any[1], 1'b1);
    check("reset if value", obs_ifval[8], 8'hA5);

    // Directed table; read_data must show the pre-update value during the access.
    prev1 = INIT;
    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].valid, tbl[k].rm, tbl[k].wm, tbl[k].wd, tbl[k].hs, tbl[k].hc);
      #1;
      check($sformatf("tbl%0d read_data", k), obs_rdata[1], prev1);
      tick();
      check($sformatf("tbl%0d value1", k), obs_value[1], tbl[k].e1_v);
      check($sformatf("tbl%0d set_pulse1", k), obs_sp[1], tbl[k].e1_sp);
      check($sformatf("tbl%0d clear_pulse1", k), obs_cp[1], tbl[k].e1_cp);
      check($sformatf("tbl%0d value8", k), obs_value[8], tbl[k].e8_v);
      prev1 = tbl[k].e1_v;
    end

    // Reset asserted in the middle of a write aborts it asynchronously.
    drive(1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00);
    #2 rst = 1'b1;
    #1;
    check("mid-access reset value1", obs_value[1], 8'hA5);
    check("mid-access reset clear_pulse1", obs_cp[1], 8'h00);
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    tick();
    check("post-reset value8", obs_value[8], 8'hA5);
    check("post-reset any8", obs_any[8], 1'b1);

    // Held hardware set with a software clear on cycle 3 (instance 8, sw priority).
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) drive(1'b1, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00);
      else        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00);
      tick();
      if (c == 3) check("held set: sw clear wins", obs_value[8][0], 1'b0);
`ifdef RGGEN_BIT_FIELD_HW_EDGE_DETECT_EN
      if (c >= 4) check($sformatf("held set cycle%0d bit0", c), obs_value[8][0], 1'b0);
`else
      if (c >= 4) check($sformatf("held set cycle%0d bit0", c), obs_value[8][0], 1'b1);
`endif
    end

    // Random cycles against the reference model.
    do_reset();
    for (int g = 0; g < NDUT; g++) exp_v[g] = INIT;
    hs_prev = '0;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] r_rm, r_wm;
      r_rm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      r_wm = ($urandom_range(0, 3) != 0) ? 8'($urandom) : 8'h00;
      drive(1'($urandom), r_rm, r_wm, 8'($urandom),
            8'($urandom) & 8'($urandom), 8'($urandom) & 8'($urandom));
`ifdef RGGEN_BIT_FIELD_HW_EDGE_DETECT_EN
      hse = hs & ~hs_prev;
`else
      hse = hs;
`endif
      #1;
      for (int g = 0; g < NDUT; g++) begin
        check($sformatf("rand%0d read_data%0d", n, g), obs_rdata[g], exp_v[g]);
        nxt[g] = model_next(exp_v[g], g % 3, g % 7, g < 7, valid, rm, wm, wd, hse, hc);
      end
      tick();
      for (int g = 0; g < NDUT; g++) begin
        check($sformatf("rand%0d value%0d", n, g), obs_value[g], nxt[g]);
        check($sformatf("rand%0d set_pulse%0d", n, g), obs_sp[g], nxt[g] & ~exp_v[g]);
        check($sformatf("rand%0d clear_pulse%0d", n, g), obs_cp[g], ~nxt[g] & exp_v[g]);
        check($sformatf("rand%0d any%0d", n, g), obs_any[g], |nxt[g]);
        exp_v[g] = nxt[g];
      end
      hs_prev = hs;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
